// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU front end.
// Holds the opcode encoding, the data width and the request payload struct.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SLL = 3'b010,
    OP_LSR = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_EQL = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    alu_op_e           op;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 8-bit ALU.
// Ports:
//   a, b   : operands
//   op     : opcode (alu_op_e)
//   result : ADD/SUB wrap mod 256, shifts use b[2:0] with zero fill,
//            EQL yields 8'h01 on equality else 8'h00
module alu_core
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLL:  result = a << b[2:0];
      OP_LSR:  result = a >> b[2:0];
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_EQL:  result = {{(DATA_W-1){1'b0}}, (a == b)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arb.sv
// Two-requester round-robin front end for the shared 8-bit ALU.
// One operation in flight: IDLE (arbitrate/accept) -> EXEC (compute) ->
// RESP (present tagged result until taken).
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a source holds valid and payload stable until that edge, and
// may drop valid beforehand. Ready never depends on the same channel's
// consumer side (req_ready_o ignores rsp_ready_i).
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   req_valid_i/req_ready_o: per-requester handshake (bit i = requester i)
//   req{0,1}_{a,b,op}_i    : request payloads
//   rsp_valid_o/rsp_ready_i: response handshake
//   rsp_id_o, rsp_data_o   : issuing requester and ALU result
//   busy_o                 : high whenever not IDLE
module alu_arb
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  input  logic [2:0]        req0_op_i,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  input  logic [2:0]        req1_op_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              busy_o
);

  state_t            state;
  req_t              opnd;
  logic              opnd_id;
  logic              last_grant;
  logic              grant_id;
  logic              transfer;
  req_t              sel_req;
  logic [DATA_W-1:0] alu_result;

  // Arbiter: contention goes to the requester that did not win last time;
  // a lone requester wins regardless of the pointer.
  always_comb begin
    grant_id    = 1'b0;
    req_ready_o = 2'b00;
    if (state == ST_IDLE) begin
      if (req_valid_i == 2'b11) grant_id = ~last_grant;
      else                      grant_id = req_valid_i[1];
      if (|req_valid_i) req_ready_o = grant_id ? 2'b10 : 2'b01;
    end
  end

  assign transfer = |(req_valid_i & req_ready_o);

  always_comb begin
    if (grant_id) sel_req = '{a: req1_a_i, b: req1_b_i, op: alu_op_e'(req1_op_i)};
    else          sel_req = '{a: req0_a_i, b: req0_b_i, op: alu_op_e'(req0_op_i)};
  end

  alu_core u_alu_core (
    .a      (opnd.a),
    .b      (opnd.b),
    .op     (opnd.op),
    .result (alu_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      opnd       <= '0;
      opnd_id    <= 1'b0;
      last_grant <= 1'b1;  // requester 0 wins the first contention
      rsp_id_o   <= 1'b0;
      rsp_data_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (transfer) begin
            opnd       <= sel_req;
            opnd_id    <= grant_id;
            last_grant <= grant_id;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data_o <= alu_result;
          rsp_id_o   <= opnd_id;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid_o = (state == ST_RESP);
  assign busy_o      = (state != ST_IDLE);

endmodule
